sub_nibble: RTL and testbench

SUB_NIBBLE -- requirements
Module: sub_nibble

---
 rtl/loong_pkg.sv | 26 ++
 rtl/loong_sbox.sv | 18 +
 rtl/sub_nibble.sv | 81 ++++++++
 tb/tb_sub_nibble.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loong_pkg.sv
// Shared types and S-box tables for the 4x4 nibble substitution layer.
// The inverse table exists only when SUBNIB_INV_EN is defined.
package loong_pkg;

  typedef logic [3:0] nibble_t;
  typedef nibble_t state_t [0:3][0:3];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam nibble_t SBOX_FWD [0:15] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

`ifdef SUBNIB_INV_EN
  localparam nibble_t SBOX_INV [0:15] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };
`endif

endpackage

// File: rtl/loong_sbox.sv
// Combinational 4-bit S-box lookup; inverse select exists under SUBNIB_INV_EN.
module loong_sbox
  import loong_pkg::*;
(
  input  logic [3:0] nib,
`ifdef SUBNIB_INV_EN
  input  logic       inv,
`endif
  output logic [3:0] sub
);

`ifdef SUBNIB_INV_EN
  assign sub = inv ? SBOX_INV[nib] : SBOX_FWD[nib];
`else
  assign sub = SBOX_FWD[nib];
`endif

endmodule

// File: rtl/sub_nibble.sv
// Row-serial nibble substitution of a 4x4 state: one row per cycle over four cycles.
// Optional inverse S-box support is enabled with SUBNIB_INV_EN.
module sub_nibble
  import loong_pkg::*;
(
  input  logic       clock,
  input  logic       rst,
  input  logic [3:0] st_subnib [0:3][0:3],
  input  logic       start,
`ifdef SUBNIB_INV_EN
  input  logic       inv,
`endif
  output logic [3:0] sub_state [0:3][0:3],
  output logic       busy,
  output logic       sub_done
);

  fsm_t       state;
  fsm_t       state_nx;
  logic [1:0] row;
  state_t     buffer;
  nibble_t    row_sub [0:3];
`ifdef SUBNIB_INV_EN
  logic       inv_q;
`endif

  for (genvar col = 0; col < 4; col++) begin : g_sbox
    loong_sbox u_sbox (
      .nib (buffer[row][col]),
`ifdef SUBNIB_INV_EN
      .inv (inv_q),
`endif
      .sub (row_sub[col])
    );
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (row == 2'd3) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      row   <= '0;
`ifdef SUBNIB_INV_EN
      inv_q <= 1'b0;
`endif
      for (int unsigned j = 0; j < 4; j++) begin
        for (int unsigned k = 0; k < 4; k++) begin
          buffer[j][k]    <= '0;
          sub_state[j][k] <= '0;
        end
      end
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        buffer <= st_subnib;
        row    <= '0;
`ifdef SUBNIB_INV_EN
        inv_q  <= inv;
`endif
      end else if (state == RUN) begin
        // Counter wraps 3 -> 0 naturally on the final row write.
        for (int unsigned k = 0; k < 4; k++) begin
          sub_state[row][k] <= row_sub[k];
        end
        row <= row + 2'd1;
      end
    end
  end

  assign busy     = (state == RUN);
  assign sub_done = (state == DONE);

endmodule

// File: tb/tb_sub_nibble.sv
// Randomised self-checking bench for sub_nibble against a table-driven reference.
// Inverse-path checks are included when SUBNIB_INV_EN is defined.
module tb_sub_nibble;

  typedef logic [3:0] st_t [0:3][0:3];

  logic       clock = 1'b0;
  logic       rst;
  logic [3:0] st_subnib [0:3][0:3];
  logic       start;
  logic       inv;
  logic [3:0] sub_state [0:3][0:3];
  logic       busy;
  logic       sub_done;

  int errors = 0;
  int checks = 0;

  logic [3:0] fwd_tab [0:15];
  st_t        prev_res;

  always #5 clock = ~clock;

  sub_nibble dut (
    .clock     (clock),
    .rst       (rst),
    .st_subnib (st_subnib),
    .start     (start),
`ifdef SUBNIB_INV_EN
    .inv       (inv),
`endif
    .sub_state (sub_state),
    .busy      (busy),
    .sub_done  (sub_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] flat(input st_t s);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        r[(15 - (4 * j + k)) * 4 +: 4] = s[j][k];
    return r;
  endfunction

  // Reference: forward table from the published constants; inverse by searching it.
  function automatic logic [3:0] sbox_ref(input logic [3:0] x, input bit inv_b);
    if (!inv_b) return fwd_tab[x];
    for (int v = 0; v < 16; v++)
      if (fwd_tab[v] == x) return 4'(v);
    return 4'hx;
  endfunction

  function automatic st_t model(input st_t s, input bit inv_b);
    st_t r;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        r[j][k] = sbox_ref(s[j][k], inv_b);
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        r[j][k] = 4'($urandom_range(0, 15));
    return r;
  endfunction

  function automatic st_t fill_state(input logic [3:0] v);
    st_t r;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        r[j][k] = v;
    return r;
  endfunction

  // One full operation: latency, busy, partial-row retention and final result.
  task automatic do_op(input st_t din, input bit inv_b, output st_t res);
    st_t exp_r;
    st_t mid;
    int  lat;
    exp_r = model(din, inv_b);
    st_subnib = din;
    inv   = inv_b;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    st_subnib = rand_state();
    check("busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    while (!sub_done && lat < 10) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 2) begin
        mid = prev_res;
        for (int k = 0; k < 4; k++) begin
          mid[0][k] = exp_r[0][k];
          mid[1][k] = exp_r[1][k];
        end
        check("mid_run_rows", flat(sub_state), flat(mid));
      end
    end
    check("latency", 64'(lat), 64'd4);
    check("result", flat(sub_state), flat(exp_r));
    check("busy_in_done", 64'(busy), 64'd0);
    @(posedge clock); #1;
    check("done_one_cycle", 64'(sub_done), 64'd0);
    check("hold_after_done", flat(sub_state), flat(exp_r));
    res = exp_r;
    prev_res = exp_r;
  endtask

  initial begin
    st_t a, b, r, r2;
    st_t pat;
    int  q[$];
    int  e, n;
    bit  inv_b;

    fwd_tab = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    rst = 1'b1; start = 1'b0; inv = 1'b0;
    st_subnib = rand_state();
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", flat(sub_state), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(sub_done), 64'd0);
    rst = 1'b0;
    prev_res = fill_state(4'h0);
    @(posedge clock); #1;

    do_op(fill_state(4'h0), 1'b0, r);
    check("all_zero_const", flat(sub_state), 64'hCCCC_CCCC_CCCC_CCCC);

    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++)
        pat[j][k] = 4'(4 * j + k);
    do_op(pat, 1'b0, r);
    check("index_pattern", flat(sub_state), 64'hC56B_90AD_3EF8_4712);

    for (int i = 0; i < 6; i++) begin
      inv_b = 1'b0;
`ifdef SUBNIB_INV_EN
      inv_b = 1'($urandom_range(0, 1));
`endif
      do_op(rand_state(), inv_b, r);
    end

`ifdef SUBNIB_INV_EN
    for (int i = 0; i < 3; i++) begin
      a = rand_state();
      do_op(a, 1'b0, r);
      do_op(r, 1'b1, r2);
      check("inv_roundtrip", flat(sub_state), flat(a));
    end
    do_op(fill_state(4'hC), 1'b1, r);
    check("inv_all_c", flat(sub_state), 64'd0);
`endif

    // Continuous start; data changed mid-RUN must only affect later captures.
    a = rand_state();
    b = rand_state();
    inv = 1'b0;
    st_subnib = a;
    start = 1'b1;
    @(posedge clock); #1;
    for (e = 1; e <= 19; e++) begin
      @(posedge clock); #1;
      if (e == 2) st_subnib = b;
      if (sub_done) begin
        q.push_back(e);
        if (e == 4)  check("cont_first", flat(sub_state), flat(model(a, 1'b0)));
        if (e == 10) check("cont_second", flat(sub_state), flat(model(b, 1'b0)));
      end
    end
    start = 1'b0;
    check("cont_pulses", 64'(q.size()), 64'd3);
    while (q.size() < 3) q.push_back(-1);
    check("cont_p0", 64'(q[0]), 64'd4);
    check("cont_p1", 64'(q[1]), 64'd10);
    check("cont_p2", 64'(q[2]), 64'd16);
    n = 0;
    while (!sub_done && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    check("cont_drain", 64'(sub_done), 64'd1);
    @(posedge clock); #1;
    prev_res = model(b, 1'b0);

    // Reset while the row counter is at 2.
    st_subnib = rand_state();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
    @(posedge clock); #1;
    rst = 1'b0;
    check("midrst_state", flat(sub_state), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(sub_done), 64'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (sub_done || busy) n++;
    end
    check("midrst_quiet", 64'(n), 64'd0);
    prev_res = fill_state(4'h0);

    // start asserted during DONE must be ignored.
    a = rand_state();
    st_subnib = a;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!sub_done && n < 10) begin
      @(posedge clock); #1;
      n++;
    end
    check("done_reached", 64'(sub_done), 64'd1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("start_in_done_busy", 64'(busy), 64'd0);
    @(posedge clock); #1;
    check("start_in_done_idle", 64'(busy), 64'd0);
    check("start_in_done_res", flat(sub_state), flat(model(a, 1'b0)));
    prev_res = model(a, 1'b0);

    do_op(rand_state(), 1'b0, r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
